// File: rtl/fir_sym_ctrl_if.sv
// Sample, coefficient-load and output bundle of the symmetric FIR.
// master: the sample source / control side; slave: the filter.
interface fir_sym_ctrl_if #(
  parameter int TAPS       = 51,
  parameter int COE_WDTH   = 18,
  parameter int XDATA_WDTH = 16,
  parameter int YDATA_WDTH = 16
);
  localparam int HALF = (TAPS + 1) / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic                         xvld;
  logic signed [XDATA_WDTH-1:0] xin;
  logic                         coe_wr;
  logic [AW-1:0]                coe_addr;
  logic signed [COE_WDTH-1:0]   coe_wdata;
  logic                         shift_wr;
  logic [5:0]                   shift_wdata;
  logic                         coe_commit;
  logic                         commit_done;
  logic                         yvld;
  logic signed [YDATA_WDTH-1:0] yout;
  logic                         ovf;

  modport master (
    output xvld, xin, coe_wr, coe_addr, coe_wdata, shift_wr, shift_wdata, coe_commit,
    input  commit_done, yvld, yout, ovf
  );

  modport slave (
    input  xvld, xin, coe_wr, coe_addr, coe_wdata, shift_wr, shift_wdata, coe_commit,
    output commit_done, yvld, yout, ovf
  );
endinterface

// File: rtl/fir_sym_ctrl.sv
// Symmetric signed FIR: pre-add, multiply, radix-4 adder tree, round/shift, narrow.
// Define FIR_SAT_EN to clamp out-of-range results and flag ovf; otherwise the output wraps.
module fir_sym_ctrl #(
  parameter int TAPS       = 51,
  parameter int COE_WDTH   = 18,
  parameter int XDATA_WDTH = 16,
  parameter int YDATA_WDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bypass,
  fir_sym_ctrl_if.slave bus
);

  function automatic int f_tree(int n);
    int t = 0;
    int v = 1;
    while (v < n) begin
      v = v * 4;
      t = t + 1;
    end
    return t;
  endfunction

  function automatic int f_nodes(int n, int l);
    int d = 1;
    for (int i = 0; i < l; i++) d = d * 4;
    return (n + d - 1) / d;
  endfunction

  function automatic int f_off(int n, int l);
    int s = 0;
    for (int i = 0; i < l; i++) s = s + f_nodes(n, i);
    return s;
  endfunction

  localparam int HALF  = (TAPS + 1) / 2;
  localparam int TREE  = f_tree(HALF);
  localparam int LAT   = 4 + TREE;
  localparam int PW    = XDATA_WDTH + 1 + COE_WDTH;
  localparam int ACC_W = XDATA_WDTH + COE_WDTH + 1 + $clog2(HALF);
  localparam int EXT_W = ACC_W + 1;
  localparam int TOTAL = f_off(HALF, TREE + 1);
  localparam int ROOT  = f_off(HALF, TREE);

  logic signed [XDATA_WDTH-1:0] r_dl [TAPS];
  logic signed [COE_WDTH-1:0]   r_shadow [HALF];
  logic signed [COE_WDTH-1:0]   r_active [HALF];
  logic signed [COE_WDTH-1:0]   w_shadow_nx [HALF];
  logic signed [COE_WDTH-1:0]   w_coe_use [HALF];
  logic [5:0]                   r_shadow_sh, r_active_sh, w_shadow_sh_nx, w_sh_use;
  logic                         r_commit_done;
  logic signed [ACC_W-1:0]      r_node [TOTAL];
  logic [5:0]                   r_shp [TREE+1];
  logic signed [EXT_W-1:0]      r_rnd;
  logic signed [YDATA_WDTH-1:0] r_bdl [LAT-1];
  logic signed [YDATA_WDTH-1:0] w_byp_in;
  logic [LAT-1:0]               r_vld;
  logic                         r_byp_s1, r_byp_s2;
  logic signed [YDATA_WDTH-1:0] r_yout;
  logic                         r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) r_dl[i] <= '0;
    end else if (bus.xvld) begin
      r_dl[0] <= bus.xin;
      for (int i = 1; i < TAPS; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  // A commit hands the multipliers the post-write shadow set in the same clock,
  // so the sample already in the delay line picks up the new set whole.
  always_comb begin
    for (int k = 0; k < HALF; k++) begin
      w_shadow_nx[k] = r_shadow[k];
      if (bus.coe_wr && (int'(bus.coe_addr) == k)) w_shadow_nx[k] = bus.coe_wdata;
      w_coe_use[k] = bus.coe_commit ? w_shadow_nx[k] : r_active[k];
    end
    w_shadow_sh_nx = bus.shift_wr ? bus.shift_wdata : r_shadow_sh;
    w_sh_use       = bus.coe_commit ? w_shadow_sh_nx : r_active_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < HALF; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
      r_shadow_sh   <= '0;
      r_active_sh   <= '0;
      r_commit_done <= 1'b0;
    end else begin
      for (int k = 0; k < HALF; k++) begin
        r_shadow[k] <= w_shadow_nx[k];
        if (bus.coe_commit) r_active[k] <= w_shadow_nx[k];
      end
      r_shadow_sh <= w_shadow_sh_nx;
      if (bus.coe_commit) r_active_sh <= w_shadow_sh_nx;
      r_commit_done <= bus.coe_commit;
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < HALF; gi++) begin : g_mac
      logic signed [XDATA_WDTH:0] w_pre;
      logic signed [PW-1:0]       w_prod;
      if ((TAPS % 2 == 1) && (gi == HALF - 1)) begin : g_ctr
        assign w_pre = (XDATA_WDTH+1)'(r_dl[gi]);
      end else begin : g_pair
        assign w_pre = (XDATA_WDTH+1)'(r_dl[gi]) + (XDATA_WDTH+1)'(r_dl[TAPS-1-gi]);
      end
      assign w_prod = PW'(w_pre) * PW'(w_coe_use[gi]);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_node[gi] <= '0;
        else        r_node[gi] <= ACC_W'(w_prod);
      end
    end

    // Tree levels live back to back in r_node; level l starts at f_off(HALF, l).
    for (gi = 1; gi <= TREE; gi++) begin : g_lvl
      for (gj = 0; gj < f_nodes(HALF, gi); gj++) begin : g_node
        localparam int DST   = f_off(HALF, gi) + gj;
        localparam int SRC   = f_off(HALF, gi - 1) + 4 * gj;
        localparam int AVAIL = f_nodes(HALF, gi - 1) - 4 * gj;
        localparam int CNT   = (AVAIL > 4) ? 4 : AVAIL;
        logic signed [ACC_W-1:0] w_sum;
        always_comb begin
          w_sum = '0;
          for (int c = 0; c < CNT; c++) w_sum = w_sum + r_node[SRC + c];
        end
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_node[DST] <= '0;
          else        r_node[DST] <= w_sum;
        end
      end
    end
  endgenerate

  // The shift travels with its sample so a commit never splits scale from coefficients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l <= TREE; l++) r_shp[l] <= '0;
    end else begin
      r_shp[0] <= w_sh_use;
      for (int l = 1; l <= TREE; l++) r_shp[l] <= r_shp[l-1];
    end
  end

  logic [5:0]              w_sh;
  logic signed [EXT_W-1:0] w_acc_ext, w_rnd, w_sum_r, w_r;
  assign w_sh = r_shp[TREE];

  // Shifts at or beyond the accumulator width always round to zero.
  always_comb begin
    w_acc_ext = EXT_W'(r_node[ROOT]);
    w_rnd     = '0;
    if ((w_sh != 6'd0) && (int'(w_sh) < ACC_W)) w_rnd[w_sh - 6'd1] = 1'b1;
    w_sum_r = w_acc_ext + w_rnd;
    if (int'(w_sh) >= ACC_W) w_r = '0;
    else                     w_r = w_sum_r >>> w_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rnd <= '0;
    else        r_rnd <= w_r;
  end

  logic signed [YDATA_WDTH-1:0] w_y;
  logic                         w_ovf;
`ifdef FIR_SAT_EN
  localparam logic signed [YDATA_WDTH-1:0] YMAX = {1'b0, {(YDATA_WDTH-1){1'b1}}};
  localparam logic signed [YDATA_WDTH-1:0] YMIN = {1'b1, {(YDATA_WDTH-1){1'b0}}};
  always_comb begin
    w_y   = r_rnd[YDATA_WDTH-1:0];
    w_ovf = 1'b0;
    if (!(&r_rnd[EXT_W-1:YDATA_WDTH-1]) && (|r_rnd[EXT_W-1:YDATA_WDTH-1])) begin
      w_ovf = 1'b1;
      w_y   = r_rnd[EXT_W-1] ? YMIN : YMAX;
    end
  end
`else
  logic w_unused_hi;
  assign w_y         = r_rnd[YDATA_WDTH-1:0];
  assign w_ovf       = 1'b0;
  assign w_unused_hi = ^r_rnd[EXT_W-1:YDATA_WDTH];
`endif

  generate
    if (XDATA_WDTH >= YDATA_WDTH) begin : g_btrunc
      assign w_byp_in = bus.xin[YDATA_WDTH-1:0];
    end else begin : g_bsext
      assign w_byp_in = {{(YDATA_WDTH-XDATA_WDTH){bus.xin[XDATA_WDTH-1]}}, bus.xin};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT - 1; i++) r_bdl[i] <= '0;
      r_vld    <= '0;
      r_byp_s1 <= 1'b0;
      r_byp_s2 <= 1'b0;
      r_yout   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_bdl[0] <= w_byp_in;
      for (int i = 1; i < LAT - 1; i++) r_bdl[i] <= r_bdl[i-1];
      r_vld    <= {r_vld[LAT-2:0], bus.xvld};
      r_byp_s1 <= bypass;
      r_byp_s2 <= r_byp_s1;
      r_yout   <= r_byp_s2 ? r_bdl[LAT-2] : w_y;
      r_ovf    <= r_byp_s2 ? 1'b0 : w_ovf;
    end
  end

  assign bus.yvld        = r_vld[LAT-1];
  assign bus.yout        = r_yout;
  assign bus.ovf         = r_ovf;
  assign bus.commit_done = r_commit_done;

endmodule
